// File: rtl/fir_pkg.sv
// Shared types and constants for the fir core and its stream sequencer.
package fir_pkg;

    localparam int FIR_TAPS   = 16;
    localparam int FIR_DATA_W = 16;

    typedef logic signed [FIR_DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        CAPTURE
    } ctrl_state_t;

endpackage

// File: rtl/fir_rate_div.sv
// Sample-rate divider: pulses strobe every div+1 cycles while en is high.
module fir_rate_div #(
    parameter int DIV_W = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim_q;
    logic [DIV_W-1:0] lim;

    // The limit is sampled at the start of each period, so a new div applies from the next wrap.
    assign lim    = (cnt == '0) ? div : lim_q;
    assign strobe = en && (cnt == lim);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lim_q <= '0;
        end else if (!en) begin
            cnt   <= '0;
        end else begin
            if (cnt == '0)
                lim_q <= div;
            cnt <= strobe ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer around the shared fir core: issues start pulses from a stream or a
// periodic strobe, buffers one result for downstream, and tracks overruns/hangs.
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIV_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     mode,
    input  logic        [DIV_W-1:0]  div,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] core_in,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic signed [DATA_W-1:0] core_out,
    output logic        [15:0]       overrun_count,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    ctrl_state_t    state;
    ctrl_state_t    state_nx;
    logic           strobe;
    logic           issue;
    logic           take;
    logic           tmo;
    logic [TCW-1:0] tcnt;

    fir_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .ck     (ck),
        .rst    (rst),
        .en     (mode),
        .div    (div),
        .strobe (strobe)
    );

    // A new sample may be issued only if its result will have somewhere to land.
    assign issue = !m_valid || m_ready;
    assign take  = (state == IDLE) && issue && (mode ? strobe : s_valid);
    // tcnt holds cycles elapsed since core_start; a done in the same cycle wins.
    assign tmo   = (state == BUSY) && !core_done && (tcnt == TCW'(TIMEOUT - 1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = START;
            START:   state_nx = BUSY;
            BUSY: begin
                if (core_done)
                    state_nx = CAPTURE;
                else if (tmo)
                    state_nx = IDLE;
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        core_start = 1'b0;
        busy       = (state != IDLE);
        if ((state == IDLE) && !mode && issue && !rst)
            s_ready = 1'b1;
        if (state == START)
            core_start = 1'b1;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            core_in       <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            tcnt          <= '0;
            timeout_err   <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (take)
                core_in <= s_data;

            if (state == START)
                tcnt <= TCW'(1);
            else if (state == BUSY)
                tcnt <= tcnt + TCW'(1);

            if (tmo)
                timeout_err <= 1'b1;

            if (state == CAPTURE) begin
                m_data  <= core_out;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (mode && strobe && !take && (overrun_count != '1))
                overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule
